// File: rtl/fhe_ram_pkg.sv
// Shared types and default geometry for the polynomial RAM block.
package fhe_ram_pkg;

  localparam int DEF_BIT_WIDTH  = 64;
  localparam int DEF_LINE_SIZE  = 4;
  localparam int DEF_ADDR_WIDTH = 10;

  // Zero-fill sequencer states.
  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_out_stage.sv
// Read output pipeline for one RAM port. With OUT_REG=1 a free-running
// stage-1 register sits in front of the enabled output register; with
// OUT_REG=0 the array read data loads the output register directly.
module ram_out_stage #(
  parameter int WIDTH   = 256,
  parameter int OUT_REG = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rd_vld_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_valid_o
);

  logic [WIDTH-1:0] out_data_q;
  logic             out_vld_q;

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [WIDTH-1:0] s1_data_q;
      logic             s1_vld_q;

      // stage 1 captures every cycle; a stalled output simply loses it
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s1_data_q <= '0;
          s1_vld_q  <= 1'b0;
        end else begin
          s1_data_q <= rdata_i;
          s1_vld_q  <= rd_vld_i;
        end
      end

      // output stage loads from stage 1 only when enabled
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          out_data_q <= '0;
          out_vld_q  <= 1'b0;
        end else if (en_i) begin
          out_data_q <= s1_data_q;
          out_vld_q  <= s1_vld_q;
        end
      end
    end else begin : g_direct
      // output stage loads straight from the array when enabled
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          out_data_q <= '0;
          out_vld_q  <= 1'b0;
        end else if (en_i) begin
          out_data_q <= rdata_i;
          out_vld_q  <= rd_vld_i;
        end
      end
    end
  endgenerate

  assign dout_o       = out_data_q;
  assign dout_valid_o = out_vld_q;

endmodule

// File: rtl/poly_ram_block_param.sv
// True dual-port line RAM with per-lane write enables, read-first
// behaviour, an optional extra output register per port and a
// sequencer that zero-fills the whole array one line per cycle.
module poly_ram_block_param
  import fhe_ram_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int LINE_SIZE  = DEF_LINE_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int OUT_REG    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_req,
  output logic                            clr_busy,
  output logic                            clr_done,
  input  logic [LINE_SIZE-1:0]            weA,
  input  logic [LINE_SIZE-1:0]            weB,
  input  logic                            reA,
  input  logic                            reB,
  input  logic [ADDR_WIDTH-1:0]           addrA,
  input  logic [ADDR_WIDTH-1:0]           addrB,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0]  dinA,
  input  logic [BIT_WIDTH*LINE_SIZE-1:0]  dinB,
  input  logic                            enA,
  input  logic                            enB,
  output logic [BIT_WIDTH*LINE_SIZE-1:0]  doutA,
  output logic [BIT_WIDTH*LINE_SIZE-1:0]  doutB,
  output logic                            doutA_valid,
  output logic                            doutB_valid
);

  localparam int LINE_W = BIT_WIDTH * LINE_SIZE;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  clr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic port_en;
  logic rd_vld_a, rd_vld_b;
  logic [LINE_W-1:0] rdata_a, rdata_b;

  // clear sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // clear sequencer next state: walk every line once, pulse done on exit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          cnt_d   = '0;
        end
      end
      CLR_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLR_CLEAR);
  assign clr_done = done_q;
  assign clr_addr = cnt_q[ADDR_WIDTH-1:0];

  // user traffic is locked out during reset and while the clear runs
  assign port_en = !rst && !clr_busy;

  // port A write path; the clear sequencer borrows this port
  always_ff @(posedge clk) begin
    if (clr_busy && !rst) begin
      mem_q[clr_addr] <= '0;
    end else if (port_en) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        if (weA[i]) begin
          mem_q[addrA][i*BIT_WIDTH +: BIT_WIDTH] <= dinA[i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  // port B write path; lanes also written by A at the same line are dropped so A wins
  always_ff @(posedge clk) begin
    if (port_en) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        if (weB[i] && !(weA[i] && (addrA == addrB))) begin
          mem_q[addrB][i*BIT_WIDTH +: BIT_WIDTH] <= dinB[i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  // read data is registered in the output stage ahead of this cycle's write, giving read-first
  assign rdata_a  = mem_q[addrA];
  assign rdata_b  = mem_q[addrB];
  assign rd_vld_a = reA && port_en;
  assign rd_vld_b = reB && port_en;

  ram_out_stage #(
    .WIDTH   (LINE_W),
    .OUT_REG (OUT_REG)
  ) u_out_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_vld_i     (rd_vld_a),
    .rdata_i      (rdata_a),
    .en_i         (enA),
    .dout_o       (doutA),
    .dout_valid_o (doutA_valid)
  );

  ram_out_stage #(
    .WIDTH   (LINE_W),
    .OUT_REG (OUT_REG)
  ) u_out_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_vld_i     (rd_vld_b),
    .rdata_i      (rdata_b),
    .en_i         (enB),
    .dout_o       (doutB),
    .dout_valid_o (doutB_valid)
  );

endmodule
